// File: rtl/capture_buffer_reader.sv
// Streams the most recent num_samples entries of the circular capture RAM, oldest first,
// to the Tx arbiter over a rdy/ack/eof handshake.
module capture_buffer_reader #(
    parameter int BITS_ADC       = 8,
    parameter int RAM_ADDR_WIDTH = 12,
    parameter int REG_DATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rqst_read,
    input  logic                      abort,
    input  logic [REG_DATA_WIDTH-1:0] num_samples,
    input  logic [RAM_ADDR_WIDTH-1:0] wr_ptr,
    output logic                      rd_en,
    output logic [RAM_ADDR_WIDTH-1:0] rd_addr,
    input  logic [BITS_ADC-1:0]       ram_data,
    output logic [7:0]                tx_data,
    output logic                      tx_rdy,
    output logic                      tx_eof,
    input  logic                      tx_ack,
    output logic                      busy
);

    localparam int CNT_W = RAM_ADDR_WIDTH + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_SEND = 2'd3;

    logic [1:0]                state_reg, state_next;
    logic [CNT_W-1:0]          cnt_reg, cnt_next;
    logic [RAM_ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [7:0]                tx_data_reg, tx_data_next;
    logic                      tx_eof_reg, tx_eof_next;
    logic [CNT_W-1:0]          cnt_start;

    // Requests larger than the RAM can only return one full buffer's worth of samples.
    generate
        if (REG_DATA_WIDTH > RAM_ADDR_WIDTH) begin : g_clamp
            localparam logic [REG_DATA_WIDTH-1:0] DEPTH = REG_DATA_WIDTH'(2 ** RAM_ADDR_WIDTH);
            assign cnt_start = (num_samples > DEPTH) ? CNT_W'(DEPTH) : CNT_W'(num_samples);
        end else begin : g_no_clamp
            assign cnt_start = CNT_W'(num_samples);
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        addr_next    = addr_reg;
        tx_data_next = tx_data_reg;
        tx_eof_next  = tx_eof_reg;
        if (abort && state_reg != ST_IDLE) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!abort && rqst_read && num_samples != '0) begin
                        cnt_next   = cnt_start;
                        // A full-depth count leaves the low bits zero, so the oldest sample is wr_ptr itself.
                        addr_next  = wr_ptr - cnt_start[RAM_ADDR_WIDTH-1:0];
                        state_next = ST_READ;
                    end
                end
                ST_READ: begin
                    state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    tx_data_next = 8'(ram_data);
                    tx_eof_next  = (cnt_reg == CNT_W'(1));
                    state_next   = ST_SEND;
                end
                ST_SEND: begin
                    if (tx_ack) begin
                        cnt_next = cnt_reg - CNT_W'(1);
                        if (cnt_reg == CNT_W'(1)) begin
                            state_next = ST_IDLE;
                        end else begin
                            addr_next  = addr_reg + RAM_ADDR_WIDTH'(1);
                            state_next = ST_READ;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            tx_data_reg <= '0;
            tx_eof_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            addr_reg    <= addr_next;
            tx_data_reg <= tx_data_next;
            tx_eof_reg  <= tx_eof_next;
        end
    end

    assign rd_en   = (state_reg == ST_READ);
    assign rd_addr = addr_reg;
    assign tx_data = tx_data_reg;
    assign tx_rdy  = (state_reg == ST_SEND);
    assign tx_eof  = tx_eof_reg && (state_reg == ST_SEND);
    assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_capture_buffer_reader.sv
// Directed bench for capture_buffer_reader: RAM model returns (addr[7:0] ^ 8'h5A) one cycle after rd_en.
module tb_capture_buffer_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rqst_read = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] num_samples = '0;
    logic [11:0] wr_ptr = '0;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [7:0]  ram_data = '0;
    logic [7:0]  tx_data;
    logic        tx_rdy;
    logic        tx_eof;
    logic        tx_ack = 1'b0;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] rd_q[$];
    logic [8:0]  tx_q[$];

    capture_buffer_reader #(
        .BITS_ADC(8),
        .RAM_ADDR_WIDTH(12),
        .REG_DATA_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rqst_read(rqst_read),
        .abort(abort),
        .num_samples(num_samples),
        .wr_ptr(wr_ptr),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .ram_data(ram_data),
        .tx_data(tx_data),
        .tx_rdy(tx_rdy),
        .tx_eof(tx_eof),
        .tx_ack(tx_ack),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) ram_data <= rd_addr[7:0] ^ 8'h5A;
    end

    // Log every RAM read and every consumed sample.
    always @(negedge clk) begin
        if (rd_en) rd_q.push_back(rd_addr);
        if (tx_rdy && tx_ack) tx_q.push_back({tx_eof, tx_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_read(input logic [11:0] wr, input logic [15:0] n);
        wr_ptr      = wr;
        num_samples = n;
        rqst_read   = 1'b1;
        tick();
        rqst_read   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit timeout);
        timeout = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) return;
            tick();
        end
        timeout = 1'b1;
    endtask

    task automatic wait_rdy(input int budget, output bit timeout);
        timeout = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (tx_rdy) return;
            tick();
        end
        timeout = 1'b1;
    endtask

    task automatic clear_logs();
        rd_q.delete();
        tx_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (rd_en !== 1'b0)    begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
        n_checks++; if (tx_rdy !== 1'b0)   begin n_fail++; $display("FAIL reset_tx_rdy: got %b expected 0", tx_rdy); end
        n_checks++; if (tx_eof !== 1'b0)   begin n_fail++; $display("FAIL reset_tx_eof: got %b expected 0", tx_eof); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        n_checks++; if (rd_addr !== 12'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
        rst = 1'b0;
        tick();
        $display("reset: outputs checked while rst held");
    endtask

    task automatic test_basic();
        bit to;
        logic [11:0] ea;
        logic [8:0]  et;
        clear_logs();
        tx_ack = 1'b1;
        start_read(12'd10, 16'd4);
        @(negedge clk);
        n_checks++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL basic_lat_rd_en: got %b expected 1", rd_en); end
        @(negedge clk);
        n_checks++; if (tx_rdy !== 1'b0) begin n_fail++; $display("FAIL basic_lat_wait: got tx_rdy=%b expected 0", tx_rdy); end
        @(negedge clk);
        n_checks++; if (tx_rdy !== 1'b1) begin n_fail++; $display("FAIL basic_lat_send: got tx_rdy=%b expected 1", tx_rdy); end
        tick();
        wait_idle(100, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got busy=%b expected 0", busy); end
        n_checks++;
        if (rd_q.size() != 4 || tx_q.size() != 4) begin
            n_fail++; $display("FAIL basic_count: got reads=%0d samples=%0d expected 4/4", rd_q.size(), tx_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                ea = 12'(6 + i);
                et = {(i == 3), ea[7:0] ^ 8'h5A};
                n_checks++; if (rd_q[i] !== ea) begin n_fail++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", i, rd_q[i], ea); end
                n_checks++; if (tx_q[i] !== et) begin n_fail++; $display("FAIL basic_sample[%0d]: got %h expected %h", i, tx_q[i], et); end
            end
        end
        $display("basic: wr_ptr=10 n=4 reads=%0d samples=%0d", rd_q.size(), tx_q.size());
    endtask

    task automatic test_wrap();
        bit to;
        logic [11:0] ea;
        logic [11:0] exp_addr [5] = '{12'd4093, 12'd4094, 12'd4095, 12'd0, 12'd1};
        logic [8:0]  et;
        clear_logs();
        tx_ack = 1'b1;
        start_read(12'd2, 16'd5);
        wait_idle(100, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL wrap_timeout: got busy=%b expected 0", busy); end
        n_checks++;
        if (rd_q.size() != 5 || tx_q.size() != 5) begin
            n_fail++; $display("FAIL wrap_count: got reads=%0d samples=%0d expected 5/5", rd_q.size(), tx_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                ea = exp_addr[i];
                et = {(i == 4), ea[7:0] ^ 8'h5A};
                n_checks++; if (rd_q[i] !== ea) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, rd_q[i], ea); end
                n_checks++; if (tx_q[i] !== et) begin n_fail++; $display("FAIL wrap_sample[%0d]: got %h expected %h", i, tx_q[i], et); end
            end
        end
        $display("wrap: wr_ptr=2 n=5 reads=%0d samples=%0d", rd_q.size(), tx_q.size());
    endtask

    task automatic test_back_pressure();
        bit to;
        clear_logs();
        tx_ack = 1'b0;
        start_read(12'd20, 16'd3);
        wait_rdy(20, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_rdy1_timeout: got tx_rdy=%b expected 1", tx_rdy); end
        tx_ack = 1'b1; tick(); tx_ack = 1'b0;
        wait_rdy(20, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_rdy2_timeout: got tx_rdy=%b expected 1", tx_rdy); end
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (tx_rdy !== 1'b1)            begin n_fail++; $display("FAIL bp_hold_rdy[%0d]: got %b expected 1", c, tx_rdy); end
            n_checks++; if (tx_data !== (8'd18 ^ 8'h5A)) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got %h expected %h", c, tx_data, 8'd18 ^ 8'h5A); end
            n_checks++; if (tx_eof !== 1'b0)            begin n_fail++; $display("FAIL bp_hold_eof[%0d]: got %b expected 0", c, tx_eof); end
            n_checks++; if (rd_q.size() != 2)           begin n_fail++; $display("FAIL bp_hold_reads[%0d]: got %0d expected 2", c, rd_q.size()); end
            if (c < 4) tick();
        end
        tx_ack = 1'b1; tick(); tx_ack = 1'b0;
        wait_rdy(20, to);
        n_checks++; if (tx_eof !== 1'b1) begin n_fail++; $display("FAIL bp_last_eof: got %b expected 1", tx_eof); end
        tx_ack = 1'b1; tick(); tx_ack = 1'b0;
        wait_idle(20, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_idle_timeout: got busy=%b expected 0", busy); end
        repeat (3) tick();
        n_checks++; if (tx_q.size() != 3) begin n_fail++; $display("FAIL bp_acks: got %0d expected 3", tx_q.size()); end
        n_checks++; if (rd_q.size() != 3) begin n_fail++; $display("FAIL bp_reads: got %0d expected 3", rd_q.size()); end
        $display("back_pressure: n=3 reads=%0d samples=%0d", rd_q.size(), tx_q.size());
    endtask

    task automatic test_zero();
        clear_logs();
        tx_ack = 1'b1;
        start_read(12'd10, 16'd0);
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (busy !== 1'b0 || rd_en !== 1'b0 || tx_rdy !== 1'b0) begin
                n_fail++; $display("FAIL zero_idle[%0d]: got busy=%b rd_en=%b tx_rdy=%b expected 0/0/0", c, busy, rd_en, tx_rdy);
            end
            tick();
        end
        n_checks++; if (rd_q.size() != 0) begin n_fail++; $display("FAIL zero_reads: got %0d expected 0", rd_q.size()); end
        $display("zero: n=0 reads=%0d", rd_q.size());
    endtask

    task automatic test_full_depth();
        bit to;
        int eofs;
        logic [11:0] ea;
        clear_logs();
        tx_ack = 1'b1;
        start_read(12'd7, 16'd5000);
        wait_idle(15000, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL full_timeout: got busy=%b expected 0", busy); end
        n_checks++;
        if (rd_q.size() != 4096 || tx_q.size() != 4096) begin
            n_fail++; $display("FAIL full_count: got reads=%0d samples=%0d expected 4096/4096", rd_q.size(), tx_q.size());
        end else begin
            eofs = 0;
            for (int i = 0; i < 4096; i++) begin
                ea = 12'(7 + i);
                n_checks++; if (rd_q[i] !== ea) begin n_fail++; $display("FAIL full_addr[%0d]: got %0d expected %0d", i, rd_q[i], ea); end
                if (tx_q[i][8]) eofs++;
            end
            n_checks++; if (rd_q[4095] !== 12'd6) begin n_fail++; $display("FAIL full_last_addr: got %0d expected 6", rd_q[4095]); end
            n_checks++; if (tx_q[4095] !== {1'b1, 8'd6 ^ 8'h5A}) begin n_fail++; $display("FAIL full_last_sample: got %h expected %h", tx_q[4095], {1'b1, 8'd6 ^ 8'h5A}); end
            n_checks++; if (eofs != 1) begin n_fail++; $display("FAIL full_eof_count: got %0d expected 1", eofs); end
        end
        $display("full_depth: wr_ptr=7 n=5000 reads=%0d samples=%0d", rd_q.size(), tx_q.size());
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_logs();
        tx_ack = 1'b0;
        start_read(12'd10, 16'd4);
        wait_rdy(20, to);
        tx_ack = 1'b1; tick(); tx_ack = 1'b0;
        wait_rdy(20, to);
        n_checks++; if (tx_data !== (8'd7 ^ 8'h5A)) begin n_fail++; $display("FAIL rstmid_data2: got %h expected %h", tx_data, 8'd7 ^ 8'h5A); end
        rst = 1'b1;
        tick();
        n_checks++;
        if (rd_en !== 1'b0 || tx_rdy !== 1'b0 || tx_eof !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00 || rd_addr !== 12'd0) begin
            n_fail++; $display("FAIL rstmid_outputs: got rd_en=%b tx_rdy=%b tx_eof=%b busy=%b tx_data=%h rd_addr=%0d expected all 0",
                               rd_en, tx_rdy, tx_eof, busy, tx_data, rd_addr);
        end
        rst = 1'b0;
        tick();
        n_checks++; if (tx_q.size() != 1 || tx_q[0][8] !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_eof: got samples=%0d expected 1 without eof", tx_q.size()); end
        clear_logs();
        tx_ack = 1'b1;
        start_read(12'd10, 16'd2);
        wait_idle(50, to);
        n_checks++;
        if (rd_q.size() != 2 || tx_q.size() != 2) begin
            n_fail++; $display("FAIL rstmid_after_count: got reads=%0d samples=%0d expected 2/2", rd_q.size(), tx_q.size());
        end else begin
            n_checks++; if (rd_q[0] !== 12'd8 || rd_q[1] !== 12'd9) begin n_fail++; $display("FAIL rstmid_after_addr: got %0d,%0d expected 8,9", rd_q[0], rd_q[1]); end
            n_checks++; if (tx_q[1] !== {1'b1, 8'd9 ^ 8'h5A} || tx_q[0] !== {1'b0, 8'd8 ^ 8'h5A}) begin
                n_fail++; $display("FAIL rstmid_after_data: got %h,%h expected %h,%h", tx_q[0], tx_q[1], {1'b0, 8'd8 ^ 8'h5A}, {1'b1, 8'd9 ^ 8'h5A});
            end
        end
        $display("reset_mid: follow-up readout reads=%0d samples=%0d", rd_q.size(), tx_q.size());
    endtask

    task automatic test_abort();
        bit to;
        clear_logs();
        tx_ack = 1'b0;
        start_read(12'd30, 16'd3);
        tick();
        n_checks++; if (busy !== 1'b1 || rd_en !== 1'b0) begin n_fail++; $display("FAIL abort_in_wait: got busy=%b rd_en=%b expected 1/0", busy, rd_en); end
        abort = 1'b1; tick(); abort = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (tx_rdy !== 1'b0 || tx_eof !== 1'b0) begin n_fail++; $display("FAIL abort_no_rdy[%0d]: got tx_rdy=%b tx_eof=%b expected 0/0", c, tx_rdy, tx_eof); end
            tick();
        end
        // abort outranks ack in SEND
        start_read(12'd40, 16'd2);
        wait_rdy(20, to);
        abort = 1'b1; tx_ack = 1'b1; tick(); abort = 1'b0; tx_ack = 1'b0;
        n_checks++; if (busy !== 1'b0 || tx_rdy !== 1'b0) begin n_fail++; $display("FAIL abort_send: got busy=%b tx_rdy=%b expected 0/0", busy, tx_rdy); end
        tick();
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL abort_send_no_read: got rd_en=%b expected 0", rd_en); end
        // abort outranks a request in IDLE
        abort = 1'b1;
        start_read(12'd50, 16'd2);
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0 || rd_en !== 1'b0) begin n_fail++; $display("FAIL abort_idle_rqst: got busy=%b rd_en=%b expected 0/0", busy, rd_en); end
        $display("abort: wait/send/idle cases done");
    endtask

    task automatic test_back_to_back();
        bit to;
        int eofs;
        clear_logs();
        tx_ack = 1'b1;
        start_read(12'd10, 16'd4);
        tick(); tick();
        start_read(12'd100, 16'd7);
        wait_idle(100, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout: got busy=%b expected 0", busy); end
        n_checks++;
        if (rd_q.size() != 4 || tx_q.size() != 4) begin
            n_fail++; $display("FAIL b2b_count: got reads=%0d samples=%0d expected 4/4", rd_q.size(), tx_q.size());
        end else begin
            eofs = 0;
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (rd_q[i] !== 12'(6 + i)) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %0d expected %0d", i, rd_q[i], 6 + i); end
                if (tx_q[i][8]) eofs++;
            end
            n_checks++; if (eofs != 1 || tx_q[3][8] !== 1'b1) begin n_fail++; $display("FAIL b2b_eof: got count=%0d last=%b expected 1/1", eofs, tx_q[3][8]); end
        end
        $display("back_to_back: second request ignored, reads=%0d samples=%0d", rd_q.size(), tx_q.size());
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_pressure();
        test_zero();
        test_full_depth();
        test_reset_mid();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
